// File: rtl/rtype_exec_ctrl_pkg.sv
// Shared definitions for the R-type execution sequencer: ALU-op encoding,
// R-type opcode/func constants, sequencer states and fault codes.
package rtype_exec_ctrl_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9,
    ALU_NOP  = 4'd15
  } alu_op_e;

  localparam logic [6:0] OPC_RTYPE = 7'b0110011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_WB,
    ST_TRAP
  } state_e;

  localparam logic [1:0] FAULT_NONE    = 2'd0;
  localparam logic [1:0] FAULT_ILLEGAL = 2'd1;
  localparam logic [1:0] FAULT_TIMEOUT = 2'd2;

  // Only the base func7 is legal everywhere; the alternate func7 is legal
  // only for ADD/SUB and SRL/SRA.
  function automatic logic rtype_legal(input logic [6:0] opcode,
                                       input logic [2:0] func3,
                                       input logic [6:0] func7);
    logic alt_ok;
    alt_ok = (func3 == F3_ADD_SUB) || (func3 == F3_SRL_SRA);
    return (opcode == OPC_RTYPE) &&
           ((func7 == F7_BASE) || ((func7 == F7_ALT) && alt_ok));
  endfunction

endpackage

// File: rtl/rtype_exec_ctrl_decoder.sv
// instr_decoder_R: field extraction and ALU-op generation for R-type words.
// Ports: instr (instruction word) -> opcode, rd, rs1, rs2, func3, func7,
// alu_op. alu_op looks only at func7[5]; legality is judged by the caller.
module instr_decoder_R
  import rtype_exec_ctrl_pkg::*;
(
  input  logic [31:0] instr,
  output logic [6:0]  opcode,
  output logic [4:0]  rd,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [2:0]  func3,
  output logic [6:0]  func7,
  output alu_op_e     alu_op
);

  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign func3  = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign func7  = instr[31:25];

  always_comb begin
    alu_op = ALU_NOP;
    unique case (func3)
      F3_ADD_SUB: alu_op = func7[5] ? ALU_SUB : ALU_ADD;
      F3_SLL:     alu_op = ALU_SLL;
      F3_SLT:     alu_op = ALU_SLT;
      F3_SLTU:    alu_op = ALU_SLTU;
      F3_XOR:     alu_op = ALU_XOR;
      F3_SRL_SRA: alu_op = func7[5] ? ALU_SRA : ALU_SRL;
      F3_OR:      alu_op = ALU_OR;
      F3_AND:     alu_op = ALU_AND;
      default:    alu_op = ALU_NOP;
    endcase
  end

endmodule

// File: rtl/rtype_exec_ctrl.sv
// rtype_exec_ctrl: multi-cycle FETCH/DECODE/EXEC/WB sequencer for R-type
// instructions with a TRAP state for illegal instructions and fetch timeouts.
// Ports: clk, rst_n (async active-low); start, halt_req control;
// imem_req/imem_addr/imem_ready/imem_rdata fetch port; rf_rs1/rf_rs2 and
// rf_rdata1/rf_rdata2 register read; alu_op/alu_a/alu_b/alu_result ALU;
// rf_we/rf_waddr/rf_wdata write-back; pc, busy, fault_code, retired status.
module rtype_exec_ctrl
  import rtype_exec_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned MAX_WAIT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        halt_req,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [4:0]  rf_rs1,
  output logic [4:0]  rf_rs2,
  input  logic [31:0] rf_rdata1,
  input  logic [31:0] rf_rdata2,
  output logic [3:0]  alu_op,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  input  logic [31:0] alu_result,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic [31:0] pc,
  output logic        busy,
  output logic [1:0]  fault_code,
  output logic [31:0] retired
);

  localparam int unsigned WAIT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

  state_e            state, state_next;
  logic [31:0]       ir;
  logic [31:0]       result;
  logic [WAIT_W-1:0] wait_cnt;
  logic              wait_last;
  logic              legal;

  logic [6:0] dec_opcode;
  logic [4:0] dec_rd, dec_rs1, dec_rs2;
  logic [2:0] dec_func3;
  logic [6:0] dec_func7;
  alu_op_e    dec_alu_op;

  instr_decoder_R u_dec (
    .instr  (ir),
    .opcode (dec_opcode),
    .rd     (dec_rd),
    .rs1    (dec_rs1),
    .rs2    (dec_rs2),
    .func3  (dec_func3),
    .func7  (dec_func7),
    .alu_op (dec_alu_op)
  );

  assign legal = rtype_legal(dec_opcode, dec_func3, dec_func7);

  // wait_cnt counts earlier non-ready cycles, so the current non-ready cycle
  // is the MAX_WAIT-th one when it equals MAX_WAIT-1.
  assign wait_last = (wait_cnt == WAIT_W'(MAX_WAIT - 1));

  assign busy = (state != ST_IDLE) && (state != ST_TRAP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    imem_req   = 1'b0;
    imem_addr  = '0;
    rf_rs1     = '0;
    rf_rs2     = '0;
    alu_op     = ALU_NOP;
    alu_a      = '0;
    alu_b      = '0;
    rf_we      = 1'b0;
    rf_waddr   = '0;
    rf_wdata   = '0;
    unique case (state)
      ST_IDLE: begin
        if (start) state_next = ST_FETCH;
      end
      ST_FETCH: begin
        imem_req  = 1'b1;
        imem_addr = pc;
        if (imem_ready)     state_next = ST_DECODE;
        else if (wait_last) state_next = ST_TRAP;
      end
      ST_DECODE: begin
        state_next = legal ? ST_EXEC : ST_TRAP;
      end
      ST_EXEC: begin
        rf_rs1     = dec_rs1;
        rf_rs2     = dec_rs2;
        alu_a      = rf_rdata1;
        alu_b      = rf_rdata2;
        alu_op     = dec_alu_op;
        state_next = ST_WB;
      end
      ST_WB: begin
        rf_we      = (dec_rd != 5'd0);
        rf_waddr   = dec_rd;
        rf_wdata   = result;
        state_next = halt_req ? ST_IDLE : ST_FETCH;
      end
      ST_TRAP: begin
        if (start) state_next = ST_FETCH;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc         <= RESET_PC;
      retired    <= '0;
      ir         <= '0;
      result     <= '0;
      fault_code <= FAULT_NONE;
      wait_cnt   <= '0;
    end else begin
      // Cleared everywhere except while stalling in FETCH, so it is always
      // zero on FETCH entry.
      wait_cnt <= '0;
      unique case (state)
        ST_FETCH: begin
          if (imem_ready) begin
            ir <= imem_rdata;
          end else if (wait_last) begin
            fault_code <= FAULT_TIMEOUT;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        ST_DECODE: begin
          if (!legal) fault_code <= FAULT_ILLEGAL;
        end
        ST_EXEC: begin
          result <= alu_result;
        end
        ST_WB: begin
          pc      <= pc + 32'd4;
          retired <= retired + 32'd1;
        end
        ST_TRAP: begin
          if (start) begin
            pc         <= RESET_PC;
            fault_code <= FAULT_NONE;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/rtype_exec_ctrl.md
# rtype_exec_ctrl

Multi-cycle control sequencer for the R-type execution path. It fetches one instruction at a time over a ready-handshaked instruction port, decodes it through the R-type decoder, and drives the register-file read ports and the combinational ALU. It then writes the result back and advances the PC. It sits between the instruction memory, the register file and the ALU, and is the only writer of the register file in the R-type-only core configuration.

## Interface
- RESET_PC, 32'h0000_0000: PC loaded at reset and on restart from TRAP
- MAX_WAIT, 16: fetch cycles without `imem_ready` before a timeout fault (≥1)
- clk  in  1  core clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; honoured only in IDLE or TRAP
- halt_req  in  1  level; sampled in WB, returns to IDLE after current retire
- imem_req  out  1  fetch request
- imem_addr  out  32  fetch address (= pc)
- imem_ready  in  1  fetch accepted, `imem_rdata` valid this cycle
- imem_rdata  in  32  instruction word
- rf_rs1, rf_rs2  out  5  register-file read addresses (combinational read)
- rf_rdata1, rf_rdata2  in  32  read data
- alu_op  out  4  ALU operation, shared ALU-op encoding; NOP outside EXEC
- alu_a, alu_b  out  32  ALU operands
- alu_result  in  32  combinational ALU result
- rf_we  out  1  write enable
- rf_waddr  out  5  write address
- rf_wdata  out  32  write data
- pc  out  32  current PC
- busy  out  1  high in any state other than IDLE and TRAP
- fault_code  out  2  0 none, 1 illegal instruction, 2 fetch timeout; held in TRAP
- retired  out  32  retired-instruction counter

## Operation
- States:
  - IDLE: `start` → FETCH
  - FETCH: `imem_req` = 1. `imem_ready` → latch IR, → DECODE. Wait counter reaches MAX_WAIT → TRAP, fault 2.
  - DECODE: legality check. Opcode must be 7'b0110011. func7 must be 0000000 for func3 ∈ {001, 010, 011, 100, 110, 111}, and 0000000 or 0100000 for func3 ∈ {000, 101}. Illegal → TRAP, fault 1. Legal → EXEC.
  - EXEC: `rf_rs1`/`rf_rs2` come from IR, `alu_a` = `rf_rdata1`, `alu_b` = `rf_rdata2`, `alu_op` = decoded op. Latch `alu_result` into the result register, → WB.
  - WB: `rf_we` = (rd ≠ 0), `rf_waddr` = rd, `rf_wdata` = result. pc += 4 (mod 2^32), retired += 1 (wraps). `halt_req` → IDLE, else → FETCH.
  - TRAP: all strobes low, `fault_code` held. `start` → pc = RESET_PC, `fault_code` = 0, → FETCH.
- rd = x0: no write, but the instruction still retires.
- `start` in FETCH/DECODE/EXEC/WB is ignored.
- Reset values: state IDLE, pc = RESET_PC, retired = 0, IR = 0, result = 0, `fault_code` = 0. `imem_req`, `rf_we` and `busy` are 0, `alu_op` = NOP, and all address and data outputs are 0.
- Asserting `rst_n` mid-instruction aborts it immediately, with no write and no retire.

## Timing
- Minimum 4 cycles per instruction: FETCH (accept cycle), DECODE, EXEC, WB.
- Each FETCH stall cycle adds 1. The wait counter clears on entering FETCH. MAX_WAIT consecutive non-ready cycles → TRAP on the next edge.
- `imem_addr` is stable while `imem_req` is high; the request is never withdrawn before ready or timeout.
- `rf_we` is a single-cycle pulse in WB. The new pc and retired values are visible the cycle after WB.
- `fault_code` updates on the edge entering TRAP.
- `halt_req` is only sampled in WB.

## Structure
- The shared package holds:
  - the ALU-op enum, including NOP
  - the R-type opcode and func3/func7 constants
  - the state enum
  - the fault-code constants
- Sub-module: one instance of `instr_decoder_R` for field extraction and `alu_op` generation. Legality is checked in this block; the decoder's output is not trusted for illegal func7.

## Test plan
- x1 = 5, x2 = 7, fetch 0x002081B3 (add x3,x1,x2), ready immediately → `rf_we` in the 4th cycle with waddr 3, wdata 12; pc 0 → 4; retired = 1.
- Fetch 0x402081B3 (sub) → `alu_op` = SUB in EXEC; wdata 0xFFFFFFFE.
- Fetch 0x022081B3 (func7 0000001) → TRAP, `fault_code` = 1, no `rf_we`, pc unchanged. Then `start` → pc = RESET_PC, fault cleared.
- Fetch 0x00208033 (rd = x0) → no `rf_we` pulse; retired increments.
- MAX_WAIT = 8, `imem_ready` held low → TRAP, `fault_code` = 2 after 8 request cycles; `busy` drops.
- `rst_n` low during EXEC, then `halt_req` high in WB of the next instruction → all outputs at reset values, no write, then IDLE with `busy` = 0 after retire.
